// File: rtl/issue_sched_pkg.sv
// Shared decode constants, FSM encoding and record types for the issue scheduler.
package issue_sched_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  // Per-slot decode result
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       rd_wr;
    logic       is_mem;
    logic       is_load;
    logic       is_ctrl;
    logic       is_ser;
  } dec_t;

  // Load delay-line entry
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_ent_t;

  // A used, non-x0 source whose pending bit is set
  function automatic logic src_hit(input logic used, input logic [4:0] r,
                                   input logic [31:0] pend);
    return used && (r != 5'd0) && pend[r];
  endfunction

endpackage

// File: rtl/issue_decode.sv
// Combinational per-slot decoder: register usage flags and issue class bits.
module issue_decode
  import issue_sched_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [6:0] opc;
  logic       unused_bits;

  assign opc         = inst_i[6:0];
  assign unused_bits = ^{inst_i[31:25], inst_i[14:12]};

  // Field extraction and classification
  always_comb begin
    dec_o          = '0;
    dec_o.rd       = inst_i[11:7];
    dec_o.rs1      = inst_i[19:15];
    dec_o.rs2      = inst_i[24:20];
    dec_o.rs1_used = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    dec_o.rs2_used = (opc == OPC_OP || opc == OPC_BRANCH || opc == OPC_STORE);
    dec_o.rd_wr    = !(opc == OPC_BRANCH || opc == OPC_STORE ||
                       opc == OPC_FENCE  || opc == OPC_SYSTEM) &&
                     (inst_i[11:7] != 5'd0);
    dec_o.is_load  = (opc == OPC_LOAD);
    dec_o.is_mem   = (opc == OPC_LOAD || opc == OPC_STORE);
    dec_o.is_ctrl  = (opc == OPC_BRANCH || opc == OPC_JAL || opc == OPC_JALR);
    dec_o.is_ser   = (opc == OPC_FENCE || opc == OPC_SYSTEM);
  end

endmodule

// File: rtl/issue_sched.sv
// Dual-issue launch controller: in-order pair issue with intra-pair hazard
// checks, load-use scoreboard, FENCE/SYSTEM serialization and statistics.
module issue_sched
  import issue_sched_pkg::*;
#(
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall_ex,
  input  logic             ex_idle,
  input  logic             slot0_valid,
  input  logic [31:0]      slot0_inst,
  input  logic             slot1_valid,
  input  logic [31:0]      slot1_inst,
  output logic             launch0,
  output logic             launch1,
  output logic             sb_busy,
  output logic [CNT_W-1:0] cnt_dual,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_stall
);

  logic [1:0][31:0] inst;
  dec_t [1:0]       dec;

  state_e                     state_q;
  logic [31:0]                pend_q, pend_d;
  sb_ent_t [LOAD_LAT-1:0]     dl_q, dl_d;
  sb_ent_t                    ld_new, dl_out;
  logic                       sb_busy_q;
  logic [CNT_W-1:0]           cnt_dual_q, cnt_single_q, cnt_stall_q;

  logic hit0, hit1, state_ok, raw, waw, pair_ok;
  logic unused_dec;

  assign inst = {slot1_inst, slot0_inst};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dec
      issue_decode u_dec (
        .inst_i (inst[g]),
        .dec_o  (dec[g])
      );
    end
  endgenerate

  assign unused_dec = dec[1].is_ctrl;

  // Issue gating: scoreboard hits, FSM condition and pair hazards
  always_comb begin
    hit0 = src_hit(dec[0].rs1_used, dec[0].rs1, pend_q) |
           src_hit(dec[0].rs2_used, dec[0].rs2, pend_q);
    hit1 = src_hit(dec[1].rs1_used, dec[1].rs1, pend_q) |
           src_hit(dec[1].rs2_used, dec[1].rs2, pend_q);
    state_ok = (state_q == S_RUN) ? ~dec[0].is_ser : (~sb_busy_q & ex_idle);
    raw = dec[0].rd_wr &
          ((dec[1].rs1_used & (dec[1].rs1 == dec[0].rd)) |
           (dec[1].rs2_used & (dec[1].rs2 == dec[0].rd)));
    waw = dec[0].rd_wr & dec[1].rd_wr & (dec[0].rd == dec[1].rd);
    pair_ok = (state_q == S_RUN) & ~dec[0].is_ctrl & ~dec[0].is_ser &
              ~dec[1].is_ser & ~(dec[0].is_mem & dec[1].is_mem) & ~raw & ~waw;
    launch0 = rst & slot0_valid & ~flush & ~stall_ex & ~hit0 & state_ok;
    launch1 = launch0 & slot1_valid & ~hit1 & pair_ok;
  end

  // Scoreboard next state: the MEM rule guarantees at most one load per cycle,
  // and a set of the same rd overrides the delay-line retirement.
  always_comb begin
    ld_new.v  = (launch0 & dec[0].is_load & (dec[0].rd != 5'd0)) |
                (launch1 & dec[1].is_load & (dec[1].rd != 5'd0));
    ld_new.rd = (launch0 & dec[0].is_load) ? dec[0].rd : dec[1].rd;
    dl_out    = dl_q[LOAD_LAT-1];
    for (int i = LOAD_LAT - 1; i > 0; i--) dl_d[i] = dl_q[i-1];
    dl_d[0] = ld_new;
    pend_d  = pend_q;
    if (dl_out.v) pend_d[dl_out.rd] = 1'b0;
    if (ld_new.v) pend_d[ld_new.rd] = 1'b1;
  end

  // Scoreboard registers; flush leaves in-flight loads tracked
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q    <= '0;
      dl_q      <= '0;
      sb_busy_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      dl_q      <= dl_d;
      sb_busy_q <= |pend_d;
    end
  end

  // RUN/DRAIN serialization FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RUN;
    end else begin
      case (state_q)
        S_RUN:   if (slot0_valid & dec[0].is_ser & ~flush) state_q <= S_DRAIN;
        S_DRAIN: if (launch0 | flush) state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
    end
  end

  // Issue statistics, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_dual_q   <= '0;
      cnt_single_q <= '0;
      cnt_stall_q  <= '0;
    end else begin
      if (launch1)             cnt_dual_q   <= cnt_dual_q + CNT_W'(1);
      if (launch0 & ~launch1)  cnt_single_q <= cnt_single_q + CNT_W'(1);
      if (slot0_valid & ~launch0 & ~flush)
                               cnt_stall_q  <= cnt_stall_q + CNT_W'(1);
    end
  end

  assign sb_busy    = sb_busy_q;
  assign cnt_dual   = cnt_dual_q;
  assign cnt_single = cnt_single_q;
  assign cnt_stall  = cnt_stall_q;

endmodule

// File: tb/tb_issue_sched.sv
// Scoreboard bench for issue_sched: expected launch pairs are queued as each
// cycle is driven and compared by a negedge monitor.
module tb_issue_sched;

  logic        clk = 1'b0;
  logic        rst, flush, stall_ex, ex_idle;
  logic        slot0_valid, slot1_valid;
  logic [31:0] slot0_inst, slot1_inst;
  logic        launch0, launch1, sb_busy;
  logic [31:0] cnt_dual, cnt_single, cnt_stall;

  int checks = 0;
  int errors = 0;
  int exp_dual = 0, exp_single = 0, exp_stall = 0;

  typedef struct {
    logic  l0;
    logic  l1;
    string nm;
  } exp_t;
  exp_t q[$];

  localparam logic [31:0] FENCE = 32'h0ff0000f;

  issue_sched #(.LOAD_LAT(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_ex(stall_ex), .ex_idle(ex_idle),
    .slot0_valid(slot0_valid), .slot0_inst(slot0_inst),
    .slot1_valid(slot1_valid), .slot1_inst(slot1_inst),
    .launch0(launch0), .launch1(launch1), .sb_busy(sb_busy),
    .cnt_dual(cnt_dual), .cnt_single(cnt_single), .cnt_stall(cnt_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_op(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic sub);
    return {(sub ? 7'h20 : 7'h00), rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, 5'b0, 7'b1100011};
  endfunction

  // Monitor: compare launch flags mid-cycle against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (launch0 !== e.l0 || launch1 !== e.l1) begin
        errors++;
        $display("FAIL %s: launch0/launch1 got %b/%b expected %b/%b",
                 e.nm, launch0, launch1, e.l0, e.l1);
      end
    end
  end

  // Drive one cycle, queue its expected launches, track expected counters
  task automatic drive(input logic v0, input logic [31:0] i0,
                       input logic v1, input logic [31:0] i1,
                       input logic fl, input logic st, input logic idle,
                       input logic e0, input logic e1, input string nm);
    slot0_valid = v0; slot0_inst = i0;
    slot1_valid = v1; slot1_inst = i1;
    flush = fl; stall_ex = st; ex_idle = idle;
    q.push_back('{e0, e1, nm});
    if (!rst) begin
      exp_dual = 0; exp_single = 0; exp_stall = 0;
    end else if (e1)         exp_dual++;
    else if (e0)             exp_single++;
    else if (v0 && !fl)      exp_stall++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    drive(1, r_op(1, 2, 3, 0), 1, r_op(4, 5, 6, 0), 0, 0, 1, 0, 0, "reset_no_launch");
    checks++;
    if (cnt_dual !== 0 || cnt_single !== 0 || cnt_stall !== 0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", cnt_dual, cnt_single, cnt_stall);
    end
    checks++;
    if (sb_busy !== 1'b0) begin errors++; $display("FAIL reset_sb_busy: got %b expected 0", sb_busy); end
    rst = 1'b1;
  endtask

  task automatic test_indep;
    drive(1, r_op(1, 2, 3, 0), 1, r_op(4, 5, 6, 0), 0, 0, 1, 1, 1, "indep_pair");
    checks++;
    if (cnt_dual !== 32'd1) begin errors++; $display("FAIL indep_cnt_dual: got %0d expected 1", cnt_dual); end
  endtask

  task automatic test_raw;
    drive(1, r_op(1, 2, 3, 0), 1, r_op(4, 1, 5, 1), 0, 0, 1, 1, 0, "raw_pair");
    drive(1, r_op(4, 1, 5, 1), 0, 32'h0, 0, 0, 1, 1, 0, "raw_second");
    checks++;
    if (cnt_single !== exp_single[31:0]) begin
      errors++; $display("FAIL raw_cnt_single: got %0d expected %0d", cnt_single, exp_single);
    end
  endtask

  task automatic test_load_use;
    logic [31:0] s0;
    drive(1, lw(7, 2, 0), 1, r_op(8, 7, 1, 0), 0, 0, 1, 1, 0, "lu_load");
    s0 = cnt_stall;
    checks++;
    if (sb_busy !== 1'b1) begin errors++; $display("FAIL lu_sb_busy: got %b expected 1", sb_busy); end
    drive(1, r_op(8, 7, 1, 0), 0, 32'h0, 0, 0, 1, 0, 0, "lu_stall1");
    drive(1, r_op(8, 7, 1, 0), 0, 32'h0, 0, 0, 1, 0, 0, "lu_stall2");
    drive(1, r_op(8, 7, 1, 0), 0, 32'h0, 0, 0, 1, 1, 0, "lu_release");
    checks++;
    if (cnt_stall - s0 !== 32'd2) begin
      errors++; $display("FAIL lu_cnt_stall: got delta %0d expected 2", cnt_stall - s0);
    end
    checks++;
    if (sb_busy !== 1'b0) begin errors++; $display("FAIL lu_sb_clear: got %b expected 0", sb_busy); end
  endtask

  task automatic test_mem_ctrl;
    drive(1, lw(9, 2, 0), 1, sw(3, 2, 12'd4), 0, 0, 1, 1, 0, "mem_pair");
    drive(1, beq(1, 2), 1, r_op(10, 11, 12, 0), 0, 0, 1, 1, 0, "branch_pair");
    drive(0, 32'h0, 0, 32'h0, 0, 0, 1, 0, 0, "idle1");
    drive(0, 32'h0, 0, 32'h0, 0, 0, 1, 0, 0, "idle2");
  endtask

  task automatic test_fence;
    logic [31:0] s0;
    drive(1, lw(5, 2, 0), 0, 32'h0, 0, 0, 0, 1, 0, "fence_load");
    s0 = cnt_stall;
    drive(1, FENCE, 1, r_op(1, 2, 3, 0), 0, 0, 0, 0, 0, "fence_enter");
    checks++;
    if (sb_busy !== 1'b1) begin errors++; $display("FAIL fence_sb_busy: got %b expected 1", sb_busy); end
    drive(1, FENCE, 1, r_op(1, 2, 3, 0), 0, 0, 0, 0, 0, "drain_busy");
    drive(1, FENCE, 1, r_op(1, 2, 3, 0), 0, 0, 0, 0, 0, "drain_not_idle");
    drive(1, FENCE, 1, r_op(1, 2, 3, 0), 0, 0, 1, 1, 0, "drain_issue");
    drive(1, r_op(1, 2, 3, 0), 1, r_op(4, 5, 6, 0), 0, 0, 1, 1, 1, "post_drain_run");
    checks++;
    if (cnt_stall - s0 !== 32'd3) begin
      errors++; $display("FAIL fence_cnt_stall: got delta %0d expected 3", cnt_stall - s0);
    end
  endtask

  task automatic test_flush;
    logic [31:0] s0;
    s0 = cnt_stall;
    drive(1, r_op(1, 2, 3, 0), 1, r_op(4, 5, 6, 0), 1, 0, 1, 0, 0, "flush_pair");
    checks++;
    if (cnt_stall !== s0) begin errors++; $display("FAIL flush_cnt_stall: got %0d expected %0d", cnt_stall, s0); end
    drive(1, r_op(1, 2, 3, 0), 1, r_op(4, 5, 6, 0), 0, 1, 1, 0, 0, "stall_ex_pair");
    drive(1, FENCE, 0, 32'h0, 0, 0, 0, 0, 0, "flush_drain_enter");
    drive(1, FENCE, 0, 32'h0, 1, 0, 0, 0, 0, "flush_in_drain");
    drive(1, r_op(1, 2, 3, 0), 1, r_op(4, 5, 6, 0), 0, 0, 0, 1, 1, "after_flush_run");
    checks++;
    if (cnt_stall !== exp_stall[31:0] || cnt_dual !== exp_dual[31:0] || cnt_single !== exp_single[31:0]) begin
      errors++;
      $display("FAIL flush_counters: got %0d/%0d/%0d expected %0d/%0d/%0d",
               cnt_dual, cnt_single, cnt_stall, exp_dual, exp_single, exp_stall);
    end
  endtask

  task automatic test_reset_in_drain;
    drive(1, FENCE, 0, 32'h0, 0, 0, 0, 0, 0, "rd_enter");
    rst = 1'b0;
    drive(1, r_op(1, 2, 3, 0), 1, r_op(4, 5, 6, 0), 0, 0, 0, 0, 0, "rd_in_reset");
    checks++;
    if (cnt_dual !== 0 || cnt_single !== 0 || cnt_stall !== 0 || sb_busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_counters: got %0d/%0d/%0d busy %b expected 0/0/0 busy 0",
               cnt_dual, cnt_single, cnt_stall, sb_busy);
    end
    rst = 1'b1;
    drive(1, r_op(1, 2, 3, 0), 1, r_op(4, 5, 6, 0), 0, 0, 0, 1, 1, "rd_back_to_run");
    checks++;
    if (cnt_dual !== 32'd1) begin errors++; $display("FAIL rd_cnt_dual: got %0d expected 1", cnt_dual); end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall_ex = 1'b0; ex_idle = 1'b1;
    slot0_valid = 1'b0; slot0_inst = '0; slot1_valid = 1'b0; slot1_inst = '0;
    @(posedge clk); #1;
    test_reset();
    test_indep();
    test_raw();
    test_load_use();
    test_mem_ctrl();
    test_fence();
    test_flush();
    test_reset_in_drain();
    drive(0, 32'h0, 0, 32'h0, 0, 0, 1, 0, 0, "final_idle");
    @(posedge clk); #1;
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL queue_drain: got %0d pending expected 0", q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
